uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serialises 8-bit bytes onto a single UART line in 8N1 (or 8N2) format: one low start bit, 8 data bits LSB first, then STOP_BITS high stop bits.
- Pairs with the UART receiver on the same board: its dout drives the far-end din.
- Parent logic loads bytes through a valid/ready handshake into a one-entry holding register, so consecutive frames go out back-to-back with no idle gap.

Parameters:
- CLKS_PER_BIT, 5208, int_clk cycles per bit period (50 MHz / 9600 baud); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- int_clk  in  1  system clock; all logic on its rising edge.
- int_rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  byte to send; sampled on the accept edge.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register empty; tx_ready = ~buf_full, taken directly from the register with no combinational path from tx_valid.
- dout  out  1  serial line, registered output, idles high.
- busy  out  1  high when state != IDLE or buf_full.
- tx_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - While int_rst_n = 0: dout = 1, tx_ready = 1, busy = 0, tx_done = 0. State is IDLE; baud counter, bit index and buf_full are all 0.
  - Reset asserted mid-frame aborts the frame immediately (dout high without waiting for an edge). The buffered byte is discarded.
- Handshake:
  - A byte is accepted on any rising edge where tx_valid && tx_ready. At that edge tx_data is copied into the holding register and buf_full is set.
  - While buf_full = 1, tx_valid is ignored and the producer holds its data.
  - On the edge where the FSM consumes the buffer, tx_ready is still low, so no accept can happen that cycle. tx_ready rises on the following cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: dout = 1. If buf_full, then on the next edge: load the shift register from the buffer, clear buf_full, reset the baud counter, go to START, and drive dout = 0.
  - Latency: a byte accepted at edge N gives dout = 0 from edge N+1 when the FSM is IDLE.
  - START: dout = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: dout = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: dout = 1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done pulses on the final cycle. On the next edge:
    - if buf_full, load the buffer and go straight to START (back-to-back, no idle cycles);
    - otherwise go to IDLE.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT), at least 1 bit.
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit-boundary edge.
  - Cleared on every frame load.
- Frame length is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles, measured from dout falling to the next START or IDLE transition. There is no cumulative drift across frames.
- Timing of changes:
  - dout changes only on bit boundaries or on a frame load.
  - busy and tx_ready update on the same edge as the state or buf_full change.

Test Plan:
1. Single byte, CLKS_PER_BIT=4, STOP_BITS=1: send 0xA5 while IDLE.
   - dout reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles long. That is 40 cycles from the falling edge at accept+1.
   - tx_done is high on cycle 40 only. busy falls on the next edge.
2. Back-to-back: present 0x00, then 0xFF with tx_valid held high continuously.
   - 0xFF is accepted one cycle after the first frame's load.
   - The second start bit follows the first stop bit with 0 idle cycles, giving 80 contiguous cycles.
   - tx_ready stays low until the second load.
3. Backpressure: assert tx_valid with 0x3C while buf_full = 1 and a frame is in progress.
   - No accept occurs until the current frame's STOP completes.
   - 0x3C is sent unaltered afterwards, even though tx_data changes while tx_ready is low (the producer must hold; the bench checks that only data present on the accept edge is used).
4. Reset mid-frame: deassert int_rst_n during DATA bit 3 with a byte buffered.
   - dout goes high before the next clock edge; tx_ready = 1, busy = 0.
   - After release, the line stays idle and the buffered byte is not sent.
5. STOP_BITS=2, CLKS_PER_BIT=3: send 0x81.
   - Frame is 33 cycles with the stop level high for 6 cycles.
   - tx_done pulses exactly once, on cycle 33.
6. Randomised soak, CLKS_PER_BIT=5: 200 random bytes with random tx_valid gaps. A reference receiver model must decode an identical byte sequence with zero framing errors.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART 8N1/8N2 serialiser with a one-entry holding register in front of the shift FSM.
// Latency: a byte accepted at edge N drives the start bit from edge N+1 when idle, or straight after the current stop bit.
// Backpressure: tx_ready = ~buf_full; while the buffer is full tx_valid is ignored and the producer must hold its data.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       int_clk,
    input  logic       int_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dout,
    output logic       busy,
    output logic       tx_done
);

    localparam int CNT_W = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       buf_dat_q, buf_dat_d;
    logic             buf_full_q, buf_full_d;
    logic             dout_q, dout_d;
    logic             bit_end;
    logic             load;

    always_ff @(posedge int_clk or negedge int_rst_n) begin
        if (!int_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            buf_dat_q  <= '0;
            buf_full_q <= 1'b0;
            dout_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            buf_dat_q  <= buf_dat_d;
            buf_full_q <= buf_full_d;
            dout_q     <= dout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        buf_dat_d  = buf_dat_q;
        buf_full_d = buf_full_q;
        dout_d     = dout_q;
        tx_done    = 1'b0;
        load       = 1'b0;
        bit_end    = (cnt_q == CNT_LAST);
        cnt_d      = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                load  = buf_full_q;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    dout_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = '0;
                        dout_d  = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                        dout_d  = shift_q[1];
                    end
                end
            end
            STOP: begin
                // idx_q counts stop bits here, so 8N2 needs no extra counter
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        tx_done = 1'b1;
                        if (buf_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d    = START;
            shift_d    = buf_dat_q;
            buf_full_d = 1'b0;
            cnt_d      = '0;
            idx_d      = '0;
            dout_d     = 1'b0;
        end

        // accept and load are mutually exclusive: one needs buf_full clear, the other set
        if (tx_valid && !buf_full_q) begin
            buf_dat_d  = tx_data;
            buf_full_d = 1'b1;
        end
    end

    assign tx_ready = ~buf_full_q;
    assign busy     = (state_q != IDLE) || buf_full_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench: three transmitter instances (4/1, 3/2 and 5/1 clocks-per-bit/stop-bits)
// driven by a shared producer task, checked cycle by cycle and by a mid-bit sampling receiver model.
module tb_uart_transmitter;

    logic       int_clk = 1'b0;
    logic       int_rst_n = 1'b0;
    logic [7:0] tx_data [3];
    logic [2:0] tx_valid = '0;
    wire  [2:0] tx_ready;
    wire  [2:0] dout;
    wire  [2:0] busy;
    wire  [2:0] tx_done;

    int tests = 0;
    int fails = 0;

    always #5 int_clk = ~int_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_transmitter #(
            .CLKS_PER_BIT((g == 0) ? 4 : (g == 1) ? 3 : 5),
            .STOP_BITS   ((g == 1) ? 2 : 1)
        ) u_dut (
            .int_clk  (int_clk),
            .int_rst_n(int_rst_n),
            .tx_data  (tx_data[g]),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .dout     (dout[g]),
            .busy     (busy[g]),
            .tx_done  (tx_done[g])
        );
    end

    function automatic int cpb_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : 5;
    endfunction

    task automatic chk_b(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Producer: sends prod_q in order; gaps drop tx_valid, garbage scrambles tx_data while not ready
    logic [7:0] prod_q[$];

    task automatic produce(input int k, input bit garbage, input int max_gap);
        for (int i = 0; i < prod_q.size(); i++) begin
            int gap;
            int waited;
            gap    = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            waited = 0;
            repeat (gap) begin
                @(negedge int_clk);
                tx_valid[k] = 1'b0;
            end
            do begin
                @(negedge int_clk);
                waited++;
                if (!tx_ready[k] && garbage) begin
                    tx_valid[k] = 1'b1;
                    tx_data[k]  = 8'($urandom);
                end
            end while (tx_ready[k] !== 1'b1 && waited < 400);
            if (tx_ready[k] !== 1'b1) begin
                chk_b("producer_ready_timeout", tx_ready[k], 1'b1);
                break;
            end
            tx_data[k]  = prod_q[i];
            tx_valid[k] = 1'b1;
        end
        @(negedge int_clk);
        tx_valid[k] = 1'b0;
    endtask

    // Line checker: bits[] holds the expected line level per bit period, LSB = first bit on the wire
    task automatic watch(input int k, input logic [63:0] bits, input int nb, input int fb,
                         input int exp_lat, input int lo1, input int hi1, input int lo2, input int hi2);
        int cpb;
        int lat;
        cpb = cpb_of(k);
        lat = 0;
        do begin
            @(negedge int_clk);
            lat++;
        end while (dout[k] !== 1'b0 && lat < 200);
        chk_i("start_latency", lat, exp_lat);
        for (int c = 1; c <= nb * cpb; c++) begin
            if (c > 1) @(negedge int_clk);
            chk_b("dout", dout[k], bits[(c - 1) / cpb]);
            chk_b("tx_done", tx_done[k], (c % (fb * cpb)) == 0);
            chk_b("busy_in_frame", busy[k], 1'b1);
            chk_b("tx_ready", tx_ready[k], !((c >= lo1 && c <= hi1) || (c >= lo2 && c <= hi2)));
        end
        @(negedge int_clk);
        chk_b("busy_after", busy[k], 1'b0);
        chk_b("dout_after", dout[k], 1'b1);
        chk_b("tx_done_after", tx_done[k], 1'b0);
        chk_b("tx_ready_after", tx_ready[k], 1'b1);
    endtask

    // Reference receiver on instance 2: hunts the start edge, samples each bit at its centre
    localparam int RX_CPB = 5;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge int_clk);
            if (int_rst_n === 1'b1 && dout[2] === 1'b0) begin
                repeat (RX_CPB / 2) @(negedge int_clk);
                if (dout[2] !== 1'b0) rx_ferr++;
                for (int j = 0; j < 8; j++) begin
                    repeat (RX_CPB) @(negedge int_clk);
                    b[j] = dout[2];
                end
                repeat (RX_CPB) @(negedge int_clk);
                if (dout[2] !== 1'b1) rx_ferr++;
                rx_q.push_back(b);
            end
        end
    end

    typedef struct {
        int         k;
        logic [7:0] data;
        logic [63:0] bits;
        int         nb;
    } vec_t;

    vec_t       tbl[5];
    logic [7:0] sent[$];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int wait_cyc;

        tbl[0] = '{k: 0, data: 8'hA5, bits: 64'b11_0100_1010,  nb: 10};
        tbl[1] = '{k: 1, data: 8'h81, bits: 64'b111_0000_0010, nb: 11};
        tbl[2] = '{k: 0, data: 8'h00, bits: 64'b10_0000_0000,  nb: 10};
        tbl[3] = '{k: 1, data: 8'hFF, bits: 64'b111_1111_1110, nb: 11};
        tbl[4] = '{k: 2, data: 8'h5A, bits: 64'b10_1011_0100,  nb: 10};
        for (int k = 0; k < 3; k++) tx_data[k] = 8'h00;

        #12;
        for (int k = 0; k < 3; k++) begin
            chk_b("reset_dout", dout[k], 1'b1);
            chk_b("reset_tx_ready", tx_ready[k], 1'b1);
            chk_b("reset_busy", busy[k], 1'b0);
            chk_b("reset_tx_done", tx_done[k], 1'b0);
        end
        @(negedge int_clk);
        int_rst_n = 1'b1;
        repeat (3) @(negedge int_clk);

        // Single frames, including 0xA5 at 4/1 and 0x81 at 3/2
        for (int i = 0; i < 5; i++) begin
            prod_q.delete();
            prod_q.push_back(tbl[i].data);
            fork
                produce(tbl[i].k, 1'b0, 0);
                watch(tbl[i].k, tbl[i].bits, tbl[i].nb, tbl[i].nb, 3, 0, -1, 0, -1);
            join
            repeat (3) @(negedge int_clk);
        end

        // Back-to-back 0x00 then 0xFF with tx_valid held high
        prod_q.delete();
        prod_q.push_back(8'h00);
        prod_q.push_back(8'hFF);
        fork
            produce(0, 1'b0, 0);
            watch(0, {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}, 20, 10, 3, 2, 40, 0, -1);
        join
        repeat (3) @(negedge int_clk);

        // Backpressure: 0x3C offered while the buffer is full, tx_data scrambled until ready
        prod_q.delete();
        prod_q.push_back(8'h11);
        prod_q.push_back(8'hC3);
        prod_q.push_back(8'h3C);
        fork
            produce(0, 1'b1, 0);
            watch(0, {1'b1, 8'h3C, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h11, 1'b0}, 30, 10, 3, 2, 40, 42, 80);
        join
        repeat (3) @(negedge int_clk);

        // Reset during data bit 3 of 0x96 with 0x2D buffered
        @(negedge int_clk);
        tx_data[0]  = 8'h96;
        tx_valid[0] = 1'b1;
        @(negedge int_clk);
        tx_data[0]  = 8'h2D;
        @(negedge int_clk);
        chk_b("rst_test_start_bit", dout[0], 1'b0);
        @(negedge int_clk);
        tx_valid[0] = 1'b0;
        chk_b("rst_test_buffered", tx_ready[0], 1'b0);
        repeat (16) @(negedge int_clk);
        chk_b("rst_test_bit3_low", dout[0], 1'b0);
        #2 int_rst_n = 1'b0;
        #1;
        chk_b("rst_async_dout", dout[0], 1'b1);
        chk_b("rst_async_tx_ready", tx_ready[0], 1'b1);
        chk_b("rst_async_busy", busy[0], 1'b0);
        chk_b("rst_async_tx_done", tx_done[0], 1'b0);
        repeat (2) @(negedge int_clk);
        int_rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge int_clk);
            if (dout[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        chk_i("rst_buffer_discarded", bad, 0);

        // Random soak on the 5-clock instance against the receiver model
        rx_q.delete();
        rx_ferr = 0;
        prod_q.delete();
        sent.delete();
        for (int i = 0; i < 200; i++) begin
            prod_q.push_back(8'($urandom));
            sent.push_back(prod_q[i]);
        end
        produce(2, 1'b0, 60);
        wait_cyc = 0;
        while (busy[2] !== 1'b0 && wait_cyc < 1000) begin
            @(negedge int_clk);
            wait_cyc++;
        end
        chk_b("soak_drained", busy[2], 1'b0);
        repeat (10) @(negedge int_clk);
        chk_i("soak_framing_errors", rx_ferr, 0);
        chk_i("soak_byte_count", rx_q.size(), 200);
        for (int i = 0; i < 200; i++) begin
            if (i < rx_q.size()) chk_i("soak_byte", int'(rx_q[i]), int'(sent[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
